// File: rtl/inv_cipher.sv
// inv_cipher: iterative AES-128 inverse cipher (decryption), one round per clock.
//
// Round keys come from an external key store: the core presents rk_idx and the
// store answers combinationally on rk in the same cycle. No key expansion here.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - ciphertext block presented
//   in_ready  - core idle and able to accept a block
//   in_data   - ciphertext, byte k at [127-8k -: 8], column-major state order
//   rk_idx    - round-key index requested this cycle (0..10)
//   rk        - round key for rk_idx, same byte order as in_data
//   out_valid - plaintext block available
//   out_ready - downstream accepts the plaintext
//   out_data  - plaintext block, same byte order as in_data
module inv_cipher (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t         fsm, fsm_next;
    logic [3:0]   rc, rc_next;
    logic [127:0] state, state_next;
    logic [3:0]   rk_idx_next;
    logic [127:0] sub_rows;
    logic [127:0] mixed;

    // GF(2^8) multiply by x, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; each step turns a^(2^k-1) into
    // a^(2^(k+1)-1), and the final squaring gives a^254. Zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        p = a;
        for (int i = 0; i < 6; i++) p = gf_mul(gf_mul(p, p), a);
        return gf_mul(p, p);
    endfunction

    // Inverse S-box computed rather than tabulated: undo the affine transform
    // (rotl 1 ^ rotl 3 ^ rotl 6 ^ 0x05), then take the field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // InvShiftRows followed by InvSubBytes: new[r][c] = isbox(old[r][(c-r) mod 4])
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*(4*c)   -: 8];
            a1 = s[127-8*(4*c+1) -: 8];
            a2 = s[127-8*(4*c+2) -: 8];
            a3 = s[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Shared round datapath: the key is added before InvMixColumns, which is
    // skipped only on the last round (rc == 0).
    always_comb begin
        sub_rows = inv_shift_sub(state) ^ rk;
        mixed    = inv_mix_columns(sub_rows);
    end

    // Next-state logic. rk_idx is computed from the next state so that the
    // registered index already matches the round about to be executed.
    always_comb begin
        fsm_next    = fsm;
        rc_next     = rc;
        state_next  = state;
        rk_idx_next = 4'd10;
        case (fsm)
            IDLE: begin
                if (in_valid) begin
                    state_next = in_data ^ rk;
                    rc_next    = 4'd9;
                    fsm_next   = ROUND;
                end
            end
            ROUND: begin
                if (rc == 4'd0) begin
                    state_next = sub_rows;
                    fsm_next   = DONE;
                end else begin
                    state_next = mixed;
                    rc_next    = rc - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
        case (fsm_next)
            ROUND:   rk_idx_next = rc_next;
            DONE:    rk_idx_next = 4'd0;
            default: rk_idx_next = 4'd10;
        endcase
    end

    // All handshake outputs are registered so none has a path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            rc        <= 4'd0;
            state     <= '0;
            rk_idx    <= 4'd10;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            fsm       <= fsm_next;
            rc        <= rc_next;
            state     <= state_next;
            rk_idx    <= rk_idx_next;
            in_ready  <= (fsm_next == IDLE);
            out_valid <= (fsm_next == DONE);
        end
    end

    assign out_data = state;

endmodule
